// File: rtl/dcache1_wb_queue.sv
// Victim write-back queue: buffers evicted dcache1 line addresses and hands
// them to L2 over a req/ack handshake, with a pending-line probe for the miss path.
module dcache1_wb_queue #(
    parameter int PADDR_WIDTH = 44,
    parameter int DEPTH       = 4,
    parameter int PTR_WIDTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_en,
    input  logic [PADDR_WIDTH-8:0]   in_addr,
    input  logic                     in_valid,
    output logic                     stall,
    output logic                     wb_req,
    output logic [PADDR_WIDTH-8:0]   wb_out_addr,
    input  logic                     wb_ack,
    input  logic [PADDR_WIDTH-8:0]   chk_addr,
    output logic                     chk_hit,
    output logic [PTR_WIDTH:0]       count,
    output logic                     err_ovf
);

    localparam int LINE_W = PADDR_WIDTH - 7;
    localparam logic [PTR_WIDTH:0] CNT_FULL  = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] CNT_STALL = (PTR_WIDTH+1)'(DEPTH - 1);

    logic [LINE_W-1:0]    ent_addr [DEPTH];
    logic [DEPTH-1:0]     ent_vld;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;

    logic full;
    logic dup;
    logic push;
    logic pop;
    logic ovf;

    // Duplicate detection includes the head being popped this edge, so a
    // re-eviction of that line merges with the write-back already completing.
    always_comb begin
        dup     = 1'b0;
        chk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_addr[i] == in_addr))
                dup = 1'b1;
            if (ent_vld[i] && (ent_addr[i] == chk_addr))
                chk_hit = 1'b1;
        end
    end

    always_comb begin
        full        = (count == CNT_FULL);
        wb_req      = (count != '0);
        stall       = (count >= CNT_STALL);
        wb_out_addr = wb_req ? ent_addr[rd_ptr] : '0;
        pop         = wb_req & wb_ack;
        push        = in_en & in_valid & ~full & ~dup;
        ovf         = in_en & in_valid &  full & ~dup;
    end

    // Control state: falling edge to line up with the tag array.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            ent_vld <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_ovf <= 1'b0;
        end else begin
            if (pop) begin
                ent_vld[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            if (push) begin
                ent_vld[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovf)
                err_ovf <= 1'b1;
        end
    end

    // Address storage carries no reset; stale slots are masked by ent_vld.
    always_ff @(negedge clk) begin
        if (push)
            ent_addr[wr_ptr] <= in_addr;
    end

endmodule

// File: tb/tb_dcache1_wb_queue.sv
// Self-checking bench for dcache1_wb_queue: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_dcache1_wb_queue;

    localparam int PADDR_WIDTH = 44;
    localparam int DEPTH       = 4;
    localparam int PTR_WIDTH   = 2;
    localparam int LW          = PADDR_WIDTH - 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_en;
    logic [LW-1:0]     in_addr;
    logic              in_valid;
    logic              stall;
    logic              wb_req;
    logic [LW-1:0]     wb_out_addr;
    logic              wb_ack;
    logic [LW-1:0]     chk_addr;
    logic              chk_hit;
    logic [PTR_WIDTH:0] count;
    logic              err_ovf;

    int n_chk = 0;
    int n_err = 0;

    logic [LW-1:0] mq[$];
    logic          m_ovf;

    dcache1_wb_queue #(
        .PADDR_WIDTH(PADDR_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_en      (in_en),
        .in_addr    (in_addr),
        .in_valid   (in_valid),
        .stall      (stall),
        .wb_req     (wb_req),
        .wb_out_addr(wb_out_addr),
        .wb_ack     (wb_ack),
        .chk_addr   (chk_addr),
        .chk_hit    (chk_hit),
        .count      (count),
        .err_ovf    (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit in_model(input logic [LW-1:0] a);
        foreach (mq[i])
            if (mq[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, ".count"},   64'(count),       64'(mq.size()));
        check_eq({tag, ".wb_req"},  64'(wb_req),      64'(mq.size() != 0));
        check_eq({tag, ".wb_addr"}, 64'(wb_out_addr), (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
        check_eq({tag, ".stall"},   64'(stall),       64'(mq.size() >= DEPTH - 1));
        check_eq({tag, ".err_ovf"}, 64'(err_ovf),     64'(m_ovf));
        check_eq({tag, ".chk_hit"}, 64'(chk_hit),     64'(in_model(chk_addr)));
    endtask

    // Drives one cycle of inputs (called just after a rising edge), advances the
    // model at the falling edge, then checks outputs just after the next rising edge.
    task automatic cycle(input string tag, input logic en, input logic vld,
                         input logic [LW-1:0] addr, input logic ack,
                         input logic [LW-1:0] probe);
        bit full, dup, pop, push;
        in_en    = en;
        in_valid = vld;
        in_addr  = addr;
        wb_ack   = ack;
        chk_addr = probe;
        full = (mq.size() == DEPTH);
        dup  = in_model(addr);
        pop  = ack && (mq.size() != 0);
        push = en && vld && !full && !dup;
        @(negedge clk);
        if (en && vld && full && !dup) m_ovf = 1'b1;
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(addr);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [LW-1:0] a;
        rst      = 1'b0;
        in_en    = 1'b0;
        in_valid = 1'b0;
        in_addr  = '0;
        wb_ack   = 1'b0;
        chk_addr = '0;
        m_ovf    = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("reset");
        do_reset();

        // Single eviction then acknowledge
        a = 37'h0_1234_5679;
        cycle("single_push", 1, 1, a, 0, a);
        check_eq("single.addr", 64'(wb_out_addr), 64'h0_1234_5679);
        check_eq("single.hit",  64'(chk_hit), 64'd1);
        cycle("single_ack", 0, 0, '0, 1, a);
        check_eq("single.cnt0", 64'(count), 64'd0);

        // Fill, full, overflow with simultaneous ack
        cycle("fill1", 1, 1, 37'h11, 0, 37'h11);
        cycle("fill2", 1, 1, 37'h21, 0, 37'h21);
        cycle("fill3", 1, 1, 37'h31, 0, 37'h31);
        check_eq("fill.stall", 64'(stall), 64'd1);
        cycle("fill4", 1, 1, 37'h41, 0, 37'h41);
        check_eq("fill.cnt4", 64'(count), 64'd4);
        cycle("ovf", 1, 1, 37'h51, 1, 37'h51);
        check_eq("ovf.err",  64'(err_ovf), 64'd1);
        check_eq("ovf.cnt",  64'(count), 64'd3);
        check_eq("ovf.head", 64'(wb_out_addr), 64'h21);
        check_eq("ovf.nohit", 64'(chk_hit), 64'd0);

        // Reset asynchronously mid-cycle with entries queued
        do_reset();
        cycle("pre_rst1", 1, 1, 37'h81, 0, 37'h81);
        cycle("pre_rst2", 1, 1, 37'h91, 0, 37'h91);
        #2;
        rst = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        check_eq("arst.count",  64'(count),  64'd0);
        check_eq("arst.wb_req", 64'(wb_req), 64'd0);
        check_eq("arst.err",    64'(err_ovf), 64'd0);
        check_eq("arst.hit",    64'(chk_hit), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle("arst_ack", 0, 0, '0, 1, 37'h81);

        // Invalid victim and duplicate merge
        cycle("inval", 1, 0, 37'h61, 0, 37'h61);
        cycle("dup1", 1, 1, 37'h71, 0, 37'h71);
        cycle("dup2", 1, 1, 37'h71, 0, 37'h71);
        check_eq("dup.cnt", 64'(count), 64'd1);
        check_eq("dup.err", 64'(err_ovf), 64'd0);
        // Re-eviction of the line being popped merges
        cycle("dup_pop", 1, 1, 37'h71, 1, 37'h71);
        check_eq("dup_pop.cnt", 64'(count), 64'd0);

        // Wrap-around in push order
        for (int i = 0; i < 10; i++) begin
            a = 37'h101 + LW'(2 * i);
            cycle("wrap_push", 1, 1, a, 0, a);
            check_eq("wrap.head", 64'(wb_out_addr), 64'(a));
            cycle("wrap_ack", 0, 0, '0, 1, a);
        end
        check_eq("wrap.cnt0", 64'(count), 64'd0);

        // Simultaneous push/pop at count 2
        cycle("sim1", 1, 1, 37'h201, 0, 37'h201);
        cycle("sim2", 1, 1, 37'h203, 0, 37'h203);
        cycle("sim_pp", 1, 1, 37'h205, 1, 37'h205);
        check_eq("sim.cnt",  64'(count), 64'd2);
        check_eq("sim.head", 64'(wb_out_addr), 64'h203);
        cycle("sim_ack1", 0, 0, '0, 1, 37'h201);
        check_eq("sim.next", 64'(wb_out_addr), 64'h205);
        cycle("sim_ack2", 0, 0, '0, 1, 37'h205);

        // Random traffic over a small address pool to provoke dups and full
        for (int n = 0; n < 3000; n++) begin
            logic [LW-1:0] ra, pa;
            ra = {LW'($urandom_range(0, 11)) << 1} | LW'(1);
            pa = {LW'($urandom_range(0, 11)) << 1} | LW'(1);
            cycle("rand", 1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 9) < 8),
                  ra, 1'($urandom_range(0, 99) < 45), pa);
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
